// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch/load-store request ports and the byte-wide RAM port of
// the shared memory sequencer. The master side is the requester/RAM owner,
// the slave side is mem_ctrl itself.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic [4:0]        mem_e;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy;

  modport master (
    output if_req, if_addr, mem_e, mem_addr, mem_wdata, flush, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );

  modport slave (
    input  if_req, if_addr, mem_e, mem_addr, mem_wdata, flush, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the single byte-wide synchronous
// RAM port shared by instruction fetch and the memory stage. Each request is
// split into one RAM cycle per byte; reads are assembled little-endian and
// loads are sign- or zero-extended. The memory stage wins arbitration and a
// granted transaction always runs to completion, except that flush abandons
// a fetch.
module mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int IF_BYTES = 4
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;

  localparam logic [1:0] IF_LAST = (IF_BYTES == 1) ? 2'd0 :
                                   (IF_BYTES == 2) ? 2'd1 : 2'd3;

  state_t            state;
  logic              owner_mem;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt;
  logic              sgn_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic              ram_wr_q;
  logic [7:0]        ram_dout_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_data_q;
  logic [31:0]       if_data_old;
  logic [31:0]       mem_rdata_q;

  logic              mem_en;
  logic              mem_wr;
  logic              mem_sgn;
  logic [1:0]        mem_last;
  logic [1:0]        cnt_next;
  logic [1:0]        cnt_prev;
  logic              flush_if;
  logic [31:0]       word_full;
  logic [31:0]       load_ext;

  // Decode {en, len, wr, sgn} into index of the last byte, plus byte-counter helpers.
  always_comb begin
    mem_en  = bus.mem_e[4];
    mem_wr  = bus.mem_e[1];
    mem_sgn = bus.mem_e[0];
    case (bus.mem_e[3:2])
      2'd0:    mem_last = 2'd0;
      2'd1:    mem_last = 2'd1;
      default: mem_last = 2'd3;
    endcase
    cnt_next = cnt + 2'd1;
    cnt_prev = cnt - 2'd1;
    flush_if = bus.flush & ~owner_mem;
  end

  // Merge the final byte arriving from RAM into the word and extend loads.
  always_comb begin
    word_full = asm_q;
    word_full[{last_q, 3'b000} +: 8] = bus.ram_din;
    case (last_q)
      2'd0:    load_ext = {{24{sgn_q & word_full[7]}}, word_full[7:0]};
      2'd1:    load_ext = {{16{sgn_q & word_full[15]}}, word_full[15:0]};
      default: load_ext = word_full;
    endcase
  end

  // Sequencer FSM: grant, issue one RAM byte per cycle, then a one-cycle done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_mem   <= 1'b0;
      addr_q      <= '0;
      last_q      <= 2'd0;
      cnt         <= 2'd0;
      sgn_q       <= 1'b0;
      wdata_q     <= '0;
      asm_q       <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      if_data_old <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= 2'd0;
          asm_q <= '0;
          if (mem_en) begin
            owner_mem  <= 1'b1;
            addr_q     <= bus.mem_addr;
            last_q     <= mem_last;
            sgn_q      <= mem_sgn & ~mem_wr;
            wdata_q    <= bus.mem_wdata;
            ram_a_q    <= bus.mem_addr;
            ram_wr_q   <= mem_wr;
            ram_dout_q <= mem_wr ? bus.mem_wdata[7:0] : 8'h00;
            state      <= mem_wr ? WR : RD;
          end else if (bus.if_req && !bus.flush) begin
            owner_mem  <= 1'b0;
            addr_q     <= bus.if_addr;
            last_q     <= IF_LAST;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            ram_a_q    <= bus.if_addr;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'h00;
            state      <= RD;
          end
        end
        RD: begin
          if (flush_if) begin
            state   <= IDLE;
            ram_a_q <= '0;
            cnt     <= 2'd0;
          end else begin
            if (cnt != 2'd0) begin
              asm_q[{cnt_prev, 3'b000} +: 8] <= bus.ram_din;
            end
            if (cnt == last_q) begin
              state   <= RD_LAST;
              ram_a_q <= '0;
            end else begin
              cnt     <= cnt_next;
              ram_a_q <= addr_q + ADDR_W'(cnt_next);
            end
          end
        end
        RD_LAST: begin
          if (flush_if) begin
            state <= IDLE;
          end else begin
            asm_q <= word_full;
            state <= DONE;
            if (owner_mem) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= load_ext;
            end else begin
              if_done_q   <= 1'b1;
              if_data_old <= if_data_q;
              if_data_q   <= word_full;
            end
          end
        end
        WR: begin
          if (cnt == last_q) begin
            state       <= DONE;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            mem_done_q  <= 1'b1;
            mem_rdata_q <= '0;
          end else begin
            cnt        <= cnt_next;
            ram_a_q    <= addr_q + ADDR_W'(cnt_next);
            ram_dout_q <= wdata_q[{cnt_next, 3'b000} +: 8];
          end
        end
        DONE: begin
          state      <= IDLE;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          if (flush_if && if_done_q) begin
            if_data_q <= if_data_old;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_done   = if_done_q & ~bus.flush;
  assign bus.if_data   = (if_done_q & bus.flush) ? if_data_old : if_data_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scenario tasks plus randomized traffic for mem_ctrl. A 1 KiB
// RAM model (address bits [9:0]) answers the RAM port; a separate reference
// byte array predicts every load, fetch and store from the access rules.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IF_BYTES(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram_dev [0:1023];
  logic [7:0]  ref_ram [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [31:0] log_a [$];
  logic        log_wr [$];
  logic [7:0]  log_d [$];
  logic [31:0] last_if = '0;

  // Synchronous byte RAM: data appears one cycle after its address.
  always @(posedge clk) begin
    if (pl_en) ram_dev[pl_addr] <= pl_data;
    else if (bus.ram_wr) ram_dev[bus.ram_a[9:0]] <= bus.ram_dout;
    bus.ram_din <= ram_dev[bus.ram_a[9:0]];
  end

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit sgn);
    longint v = 0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] a = addr + 32'(k);
      v += longint'(ref_ram[a[9:0]]) * (longint'(1) << (8 * k));
    end
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic pl(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a[9:0]; pl_data = d; ref_ram[a[9:0]] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic step_until_done(input bit want_mem, output int edges, output bit saw_other);
    log_a.delete(); log_wr.delete(); log_d.delete();
    edges = -1; saw_other = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      log_a.push_back(bus.ram_a); log_wr.push_back(bus.ram_wr); log_d.push_back(bus.ram_dout);
      if (want_mem ? bus.if_done : bus.mem_done) saw_other = 1'b1;
      if (want_mem ? bus.mem_done : bus.if_done) begin
        edges = c;
        break;
      end
    end
  endtask

  task automatic release_idle();
    bus.if_req = 1'b0; bus.mem_e = 5'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.mem_e = 0; bus.mem_addr = 0;
    bus.mem_wdata = 0; bus.flush = 0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) pl(32'(i), 8'($urandom));
    n_tests++;
    if ({bus.busy, bus.if_done, bus.mem_done, bus.ram_wr} !== 4'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {bus.busy, bus.if_done, bus.mem_done, bus.ram_wr});
    end
    n_tests++;
    if (bus.ram_a !== 32'h0 || bus.ram_dout !== 8'h0) begin
      n_fail++; $display("[TB] FAIL reset_ram_port: got a=%h d=%h want 0", bus.ram_a, bus.ram_dout);
    end
    n_tests++;
    if (bus.if_data !== 32'h0 || bus.mem_rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got if=%h mem=%h want 0", bus.if_data, bus.mem_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_idle: busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_fetch();
    int e; bit s;
    pl(32'h100, 8'h13); pl(32'h101, 8'h05); pl(32'h102, 8'h00); pl(32'h103, 8'h00);
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    step_until_done(1'b0, e, s);
    n_tests++;
    if (e !== 6) begin n_fail++; $display("[TB] FAIL fetch_latency: got %0d want 6", e); end
    n_tests++;
    if (bus.if_data !== 32'h00000513) begin
      n_fail++; $display("[TB] FAIL fetch_data: got %h want 00000513", bus.if_data);
    end
    n_tests++;
    for (int k = 0; k < 4; k++) begin
      if (log_a[k] !== 32'h100 + 32'(k) || log_wr[k] !== 1'b0) begin
        n_fail++; $display("[TB] FAIL fetch_addr_seq: k=%0d got a=%h wr=%b want a=%h wr=0", k, log_a[k], log_wr[k], 32'h100 + 32'(k));
        break;
      end
    end
    last_if = 32'h00000513;
    release_idle();
  endtask

  task automatic test_loads();
    int e; bit s;
    logic [4:0]  es [3] = '{5'b10001, 5'b10000, 5'b10101};
    logic [31:0] ex [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    int          lt [3] = '{3, 3, 4};
    pl(32'h20, 8'h80);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin pl(32'h20, 8'h01); pl(32'h21, 8'h80); end
      bus.mem_addr = 32'h20; bus.mem_e = es[i];
      step_until_done(1'b1, e, s);
      n_tests++;
      if (e !== lt[i] || bus.mem_rdata !== ex[i]) begin
        n_fail++; $display("[TB] FAIL load_%0d: got lat=%0d data=%h want lat=%0d data=%h", i, e, bus.mem_rdata, lt[i], ex[i]);
      end
      release_idle();
    end
  endtask

  task automatic test_store();
    int e; bit s;
    logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEADBEEF; bus.mem_e = 5'b11110;
    step_until_done(1'b1, e, s);
    n_tests++;
    if (e !== 5 || bus.mem_rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL store_done: got lat=%0d rdata=%h want lat=5 rdata=0", e, bus.mem_rdata);
    end
    n_tests++;
    for (int k = 0; k < 5; k++) begin
      logic       wwr = (k < 4);
      logic [31:0] wa = (k < 4) ? 32'h40 + 32'(k) : 32'h0;
      logic [7:0]  wd = (k < 4) ? eb[k] : 8'h00;
      if (log_wr[k] !== wwr || log_a[k] !== wa || log_d[k] !== wd) begin
        n_fail++; $display("[TB] FAIL store_seq: k=%0d got wr=%b a=%h d=%h want wr=%b a=%h d=%h", k, log_wr[k], log_a[k], log_d[k], wwr, wa, wd);
        break;
      end
    end
    for (int k = 0; k < 4; k++) ref_ram[10'h40 + 10'(k)] = eb[k];
    release_idle();
    bus.mem_e = 5'b11100;
    step_until_done(1'b1, e, s);
    n_tests++;
    if (bus.mem_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL store_readback: got %h want deadbeef", bus.mem_rdata);
    end
    release_idle();
  endtask

  task automatic test_arbitration();
    int e; bit s;
    logic [31:0] exp_if = ref_load(32'h200, 4, 1'b0);
    logic [31:0] exp_m  = ref_load(32'h300, 2, 1'b0);
    bus.if_addr = 32'h200; bus.if_req = 1'b1;
    bus.mem_addr = 32'h300; bus.mem_e = 5'b10100;
    step_until_done(1'b1, e, s);
    n_tests++;
    if (e !== 4 || s !== 1'b0 || bus.mem_rdata !== exp_m) begin
      n_fail++; $display("[TB] FAIL arb_mem_first: got lat=%0d if_seen=%b data=%h want lat=4 if_seen=0 data=%h", e, s, bus.mem_rdata, exp_m);
    end
    bus.mem_e = 5'd0;
    step_until_done(1'b0, e, s);
    n_tests++;
    if (e !== 7 || log_a[1] !== 32'h200) begin
      n_fail++; $display("[TB] FAIL arb_if_after: got lat=%0d first_a=%h want lat=7 first_a=00000200", e, log_a[1]);
    end
    n_tests++;
    if (bus.if_data !== exp_if) begin
      n_fail++; $display("[TB] FAIL arb_if_data: got %h want %h", bus.if_data, exp_if);
    end
    last_if = exp_if;
    release_idle();
  endtask

  task automatic test_flush();
    int e; bit s; int n_done; int n_wr;
    logic [31:0] exp_m = ref_load(32'h310, 2, 1'b1);
    bus.if_addr = 32'h120; bus.if_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.flush = 1'b1; bus.if_req = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_busy: got %b want 0", bus.busy); end
    n_done = 0; n_wr = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_done += int'(bus.if_done); n_wr += int'(bus.ram_wr);
    end
    n_tests++;
    if (n_done !== 0 || n_wr !== 0 || bus.if_data !== last_if) begin
      n_fail++; $display("[TB] FAIL flush_quiet: got dones=%0d writes=%0d if_data=%h want 0 0 %h", n_done, n_wr, bus.if_data, last_if);
    end
    bus.if_req = 1'b1; bus.flush = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_idle_block: busy got %b want 0", bus.busy); end
    bus.flush = 1'b0;
    step_until_done(1'b0, e, s);
    n_tests++;
    if (e !== 6 || bus.if_data !== ref_load(32'h120, 4, 1'b0)) begin
      n_fail++; $display("[TB] FAIL flush_refetch: got lat=%0d data=%h want lat=6 data=%h", e, bus.if_data, ref_load(32'h120, 4, 1'b0));
    end
    last_if = ref_load(32'h120, 4, 1'b0);
    release_idle();
    bus.mem_addr = 32'h310; bus.mem_e = 5'b10101; bus.flush = 1'b1;
    step_until_done(1'b1, e, s);
    n_tests++;
    if (e !== 4 || bus.mem_rdata !== exp_m) begin
      n_fail++; $display("[TB] FAIL flush_mem: got lat=%0d data=%h want lat=4 data=%h", e, bus.mem_rdata, exp_m);
    end
    bus.flush = 1'b0;
    release_idle();
  endtask

  task automatic test_flush_done();
    bus.if_addr = 32'h140; bus.if_req = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    #1;
    n_tests++;
    if (bus.if_done !== 1'b0 || bus.if_data !== last_if) begin
      n_fail++; $display("[TB] FAIL flush_done_cycle: got done=%b data=%h want done=0 data=%h", bus.if_done, bus.if_data, last_if);
    end
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.if_data !== last_if) begin
      n_fail++; $display("[TB] FAIL flush_done_after: got busy=%b data=%h want busy=0 data=%h", bus.busy, bus.if_data, last_if);
    end
  endtask

  task automatic test_wrap();
    int e; bit s;
    logic [31:0] exp_w = ref_load(32'hFFFFFFFF, 4, 1'b0);
    bus.mem_addr = 32'hFFFFFFFF; bus.mem_e = 5'b11100;
    step_until_done(1'b1, e, s);
    n_tests++;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] wa = 32'hFFFFFFFF + 32'(k);
      if (log_a[k] !== wa) begin
        n_fail++; $display("[TB] FAIL wrap_addr_seq: k=%0d got %h want %h", k, log_a[k], wa);
        break;
      end
    end
    n_tests++;
    if (e !== 6 || bus.mem_rdata !== exp_w) begin
      n_fail++; $display("[TB] FAIL wrap_data: got lat=%0d data=%h want lat=6 data=%h", e, bus.mem_rdata, exp_w);
    end
    release_idle();
  endtask

  task automatic test_reset_mid_write();
    int e; bit s; int n_wr;
    logic [31:0] wd = 32'hA1B2C3D4;
    bus.mem_addr = 32'h80; bus.mem_wdata = wd; bus.mem_e = 5'b11110;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.ram_wr, bus.mem_done, bus.if_done} !== 4'b0 || bus.ram_a !== 32'h0 ||
        bus.ram_dout !== 8'h0 || bus.if_data !== 32'h0 || bus.mem_rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got flags=%b a=%h d=%h if=%h mem=%h want all 0",
        {bus.busy, bus.ram_wr, bus.mem_done, bus.if_done}, bus.ram_a, bus.ram_dout, bus.if_data, bus.mem_rdata);
    end
    n_wr = 0;
    repeat (3) begin @(posedge clk); #1; n_wr += int'(bus.ram_wr); end
    n_tests++;
    if (n_wr !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_write: got %0d writes want 0", n_wr); end
    rst_n = 1'b1;
    last_if = 32'h0;
    step_until_done(1'b1, e, s);
    n_tests++;
    if (e !== 5 || log_a[0] !== 32'h80 || log_d[0] !== 8'hD4 || log_a[3] !== 32'h83 || log_d[3] !== 8'hA1) begin
      n_fail++; $display("[TB] FAIL midreset_restart: got lat=%0d a0=%h d0=%h a3=%h d3=%h want 5 80 d4 83 a1",
        e, log_a[0], log_d[0], log_a[3], log_d[3]);
    end
    for (int k = 0; k < 4; k++) ref_ram[10'h80 + 10'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
    release_idle();
    bus.mem_e = 5'b11100;
    step_until_done(1'b1, e, s);
    n_tests++;
    if (bus.mem_rdata !== wd) begin
      n_fail++; $display("[TB] FAIL midreset_readback: got %h want %h", bus.mem_rdata, wd);
    end
    release_idle();
  endtask

  task automatic test_random();
    int e; bit s;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr = $urandom;
      bit          is_if = ($urandom_range(0, 3) == 0);
      logic [1:0]  len = 2'($urandom_range(0, 3));
      bit          wr = is_if ? 1'b0 : 1'($urandom_range(0, 1));
      bit          sg = 1'($urandom_range(0, 1));
      logic [31:0] wd = $urandom;
      int          n = is_if ? 4 : len_bytes(len);
      int          exp_lat = wr ? n + 1 : n + 2;
      logic [31:0] exp_d = wr ? 32'h0 : ref_load(addr, n, sg && !is_if);
      logic [31:0] got_d;
      if (is_if) begin
        bus.if_addr = addr; bus.if_req = 1'b1;
      end else begin
        bus.mem_addr = addr; bus.mem_wdata = wd; bus.mem_e = {1'b1, len, wr, sg};
      end
      step_until_done(!is_if, e, s);
      got_d = is_if ? bus.if_data : bus.mem_rdata;
      n_tests++;
      if (e !== exp_lat || got_d !== exp_d) begin
        n_fail++; $display("[TB] FAIL rand_%0d: if=%0b wr=%0b n=%0d got lat=%0d data=%h want lat=%0d data=%h",
          t, is_if, wr, n, e, got_d, exp_lat, exp_d);
      end
      n_tests++;
      for (int k = 0; k < n; k++) begin
        logic [31:0] wa = addr + 32'(k);
        logic [7:0]  wb = wr ? 8'((wd >> (8 * k)) & 32'hFF) : 8'h00;
        if (log_a[k] !== wa || log_wr[k] !== 1'(wr) || log_d[k] !== wb) begin
          n_fail++; $display("[TB] FAIL rand_seq_%0d: k=%0d got a=%h wr=%b d=%h want a=%h wr=%b d=%h",
            t, k, log_a[k], log_wr[k], log_d[k], wa, wr, wb);
          break;
        end
      end
      if (wr) begin
        for (int k = 0; k < n; k++) begin
          logic [31:0] wa = addr + 32'(k);
          ref_ram[wa[9:0]] = 8'((wd >> (8 * k)) & 32'hFF);
        end
      end
      if (is_if) last_if = exp_d;
      release_idle();
    end
  endtask

  // Bound the whole run in case the DUT stops responding entirely.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_loads();
    test_store();
    test_arbitration();
    test_flush();
    test_flush_done();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
